// File: rtl/demux2_pkg.sv
// Shared constants for the two-way frame demultiplexer: FSM encoding, widths.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
package demux2_pkg;

   // Sample width on the stream datapath
   localparam int DATA_W = 16;

   // Width of the optional per-port frame counters
   localparam int CNT_W = 8;

   // Frame-tracking FSM encoding (kept as plain constants for legacy tools)
   localparam logic [1:0] IDLE    = 2'd0;
   localparam logic [1:0] FRAME_A = 2'd1;
   localparam logic [1:0] FRAME_B = 2'd2;

   // State entered when a multi-beat frame opens towards the given port
   function automatic logic [1:0] open_state(input logic to_b);
      return to_b ? FRAME_B : FRAME_A;
   endfunction

endpackage

// File: rtl/demux2_stream_if.sv
// Valid/ready sample stream bundle with a Last marker per beat.
// Latency: n/a (wiring only).
// Backpressure: beat transfers when valid & ready; the master holds data/last while valid & !ready.
interface demux2_stream_if #(
   parameter int DATA_W = demux2_pkg::DATA_W
) ();

   logic [DATA_W-1:0] data;
   logic              valid;
   logic              last;
   logic              ready;

   // Producer side of the stream
   modport master (
      output data,
      output valid,
      output last,
      input  ready
   );

   // Consumer side of the stream
   modport slave (
      input  data,
      input  valid,
      input  last,
      output ready
   );

endinterface

// File: rtl/demux2_stream_reg_slice.sv
// One-entry valid/ready register slice carrying a sample and its Last flag.
// Latency: one cycle from load to valid output.
// Backpressure: can_load = !valid | ready, so a full slice accepts a new beat in the cycle it drains.
module stream_reg_slice
   import demux2_pkg::*;
#(
   parameter int W = DATA_W
) (
   input  logic         clk,
   input  logic         rst_n,
   // Load side: the caller only asserts load while can_load is high
   input  logic         load,
   input  logic [W-1:0] load_data,
   input  logic         load_last,
   output logic         can_load,
   // Downstream side
   input  logic         ready,
   output logic         valid,
   output logic [W-1:0] data,
   output logic         last
);

   // Free when empty, or when the held beat leaves this cycle
   assign can_load = !valid | ready;

   // Valid flag: set on load (wins over drain), cleared when the held beat is taken
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         valid <= 1'b0;
      end else if (load) begin
         valid <= 1'b1;
      end else if (ready) begin
         valid <= 1'b0;
      end
   end

   // Payload only changes on load, so it stays stable while stalled
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         data <= '0;
         last <= 1'b0;
      end else if (load) begin
         data <= load_data;
         last <= load_last;
      end
   end

endmodule

// File: rtl/demux2_stream.sv
// Two-way frame demultiplexer: steers each input frame to port A or B using Sel sampled on its first beat.
// Latency: one cycle (per-port register slice), one beat per cycle when the routed port is ready.
// Backpressure: in_ready follows only the routed port's slice; the other port keeps draining on its own.
// Optional build macro DEMUX2_FRAME_CNT_EN adds per-port completed-frame counters frames_a/frames_b.
module demux2_stream
   import demux2_pkg::*;
(
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    sel,
   demux2_stream_if.slave          in_s,
   demux2_stream_if.master         out_a,
   demux2_stream_if.master         out_b
`ifdef DEMUX2_FRAME_CNT_EN
   ,
   output logic [CNT_W-1:0]        frames_a,
   output logic [CNT_W-1:0]        frames_b
`endif
);

   logic [1:0] state;
   logic [1:0] state_nxt;
   logic       route_b;
   logic       a_can_load;
   logic       b_can_load;
   logic       in_ready;
   logic       accept;
   logic       load_a;
   logic       load_b;

   // Destination of the current beat: live Sel only between frames, otherwise the open frame's port
   always_comb begin
      route_b = 1'b0;
      case (state)
         IDLE:    route_b = sel;
         FRAME_B: route_b = 1'b1;
         default: route_b = 1'b0;
      endcase
   end

   // Readiness is taken from the routed slice only, never from the other port
   assign in_ready   = route_b ? b_can_load : a_can_load;
   assign in_s.ready = in_ready;
   assign accept     = in_s.valid & in_ready;
   assign load_a     = accept & !route_b;
   assign load_b     = accept &  route_b;

   // Frame tracking: open on a non-last accepted beat from IDLE, close on an accepted last beat
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE, FRAME_A, FRAME_B: begin
            if (accept) begin
               state_nxt = in_s.last ? IDLE : open_state(route_b);
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   // State register; reset discards any partially forwarded frame
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   stream_reg_slice #(.W(DATA_W)) u_slice_a (
      .clk       (clk),
      .rst_n     (rst_n),
      .load      (load_a),
      .load_data (in_s.data),
      .load_last (in_s.last),
      .can_load  (a_can_load),
      .ready     (out_a.ready),
      .valid     (out_a.valid),
      .data      (out_a.data),
      .last      (out_a.last)
   );

   stream_reg_slice #(.W(DATA_W)) u_slice_b (
      .clk       (clk),
      .rst_n     (rst_n),
      .load      (load_b),
      .load_data (in_s.data),
      .load_last (in_s.last),
      .can_load  (b_can_load),
      .ready     (out_b.ready),
      .valid     (out_b.valid),
      .data      (out_b.data),
      .last      (out_b.last)
   );

`ifdef DEMUX2_FRAME_CNT_EN
   // Count frames completed towards A; wraps naturally at the counter width
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         frames_a <= '0;
      end else if (load_a && in_s.last) begin
         frames_a <= frames_a + 1'b1;
      end
   end

   // Count frames completed towards B; wraps naturally at the counter width
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         frames_b <= '0;
      end else if (load_b && in_s.last) begin
         frames_b <= frames_b + 1'b1;
      end
   end
`endif

endmodule

// File: tb/tb_demux2_stream.sv
// Self-checking bench for demux2_stream: directed scenarios plus a randomized run against a queue model.
// Latency: n/a (testbench).
// Backpressure: downstream ready lines are driven directly, randomly in the randomized run.
module tb_demux2_stream;
   import demux2_pkg::*;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   logic sel   = 1'b0;

   int n_tests = 0;
   int n_fail  = 0;

   demux2_stream_if in_s  ();
   demux2_stream_if out_a ();
   demux2_stream_if out_b ();

`ifdef DEMUX2_FRAME_CNT_EN
   logic [7:0] frames_a;
   logic [7:0] frames_b;
`endif

   demux2_stream dut (
      .clk   (clk),
      .rst_n (rst_n),
      .sel   (sel),
      .in_s  (in_s),
      .out_a (out_a),
      .out_b (out_b)
`ifdef DEMUX2_FRAME_CNT_EN
      ,
      .frames_a (frames_a),
      .frames_b (frames_b)
`endif
   );

   always #5 clk = ~clk;

   // Hard bound on the whole run
   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic drive(input logic v, input logic s, input logic [15:0] d, input logic l);
      in_s.valid = v;
      sel        = s;
      in_s.data  = d;
      in_s.last  = l;
   endtask

   task automatic set_rdy(input logic ra, input logic rb);
      out_a.ready = ra;
      out_b.ready = rb;
   endtask

   task automatic next_cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic apply_reset();
      drive(1'b0, 1'b0, 16'h0, 1'b0);
      set_rdy(1'b1, 1'b1);
      rst_n = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      next_cyc();
   endtask

   task automatic test_reset();
      drive(1'b0, 1'b0, 16'h0, 1'b0);
      set_rdy(1'b1, 1'b1);
      rst_n = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      n_tests++;
      if (out_a.valid !== 1'b0 || out_b.valid !== 1'b0) begin
         n_fail++;
         $display("FAIL rst_valids: a=%b b=%b want 0 0", out_a.valid, out_b.valid);
      end
      n_tests++;
      if (out_a.data !== 16'h0 || out_b.data !== 16'h0 || out_a.last !== 1'b0 || out_b.last !== 1'b0) begin
         n_fail++;
         $display("FAIL rst_payload: a=%h/%b b=%h/%b want 0000/0 0000/0",
                  out_a.data, out_a.last, out_b.data, out_b.last);
      end
      rst_n = 1'b1;
      next_cyc();
      @(negedge clk);
      n_tests++;
      if (in_s.ready !== 1'b1 || dut.state !== IDLE) begin
         n_fail++;
         $display("FAIL rst_ready_state: ready=%b state=%0d want 1 %0d", in_s.ready, dut.state, IDLE);
      end
      next_cyc();
   endtask

   // Four-beat frame to A with everything ready: one beat per cycle, one-cycle latency
   task automatic test_frame_a();
      set_rdy(1'b1, 1'b1);
      for (int i = 1; i <= 4; i++) begin
         drive(1'b1, 1'b0, 16'(i), i == 4);
         @(negedge clk);
         n_tests++;
         if (in_s.ready !== 1'b1) begin
            n_fail++;
            $display("FAIL fa_ready%0d: got %b want 1", i, in_s.ready);
         end
         n_tests++;
         if (i == 1 && out_a.valid !== 1'b0) begin
            n_fail++;
            $display("FAIL fa_early: a_valid=%b want 0", out_a.valid);
         end else if (i > 1 && (out_a.valid !== 1'b1 || out_a.data !== 16'(i - 1) || out_b.valid !== 1'b0)) begin
            n_fail++;
            $display("FAIL fa_beat%0d: a=%b/%h b_valid=%b want 1/%h 0",
                     i - 1, out_a.valid, out_a.data, out_b.valid, 16'(i - 1));
         end
         next_cyc();
      end
      drive(1'b0, 1'b0, 16'h0, 1'b0);
      @(negedge clk);
      n_tests++;
      if (out_a.valid !== 1'b1 || out_a.data !== 16'h0004 || out_a.last !== 1'b1 || out_b.valid !== 1'b0) begin
         n_fail++;
         $display("FAIL fa_last: a=%b/%h/%b b_valid=%b want 1/0004/1 0",
                  out_a.valid, out_a.data, out_a.last, out_b.valid);
      end
      next_cyc();
      @(negedge clk);
      n_tests++;
      if (out_a.valid !== 1'b0 || out_b.valid !== 1'b0) begin
         n_fail++;
         $display("FAIL fa_drained: a=%b b=%b want 0 0", out_a.valid, out_b.valid);
      end
      next_cyc();
   endtask

   // Sel toggling mid-frame must not move the frame; the next frame honours Sel
   task automatic test_sel_ignored();
      logic [3:0] pat;
      pat = 4'b0110;
      set_rdy(1'b1, 1'b1);
      for (int i = 0; i < 5; i++) begin
         if (i < 4) drive(1'b1, pat[i], 16'h0030 + 16'(i), i == 3);
         else       drive(1'b0, 1'b0, 16'h0, 1'b0);
         @(negedge clk);
         if (i > 0) begin
            n_tests++;
            if (out_a.valid !== 1'b1 || out_a.data !== 16'h0030 + 16'(i - 1) || out_b.valid !== 1'b0) begin
               n_fail++;
               $display("FAIL si_beat%0d: a=%b/%h b_valid=%b want 1/%h 0",
                        i - 1, out_a.valid, out_a.data, out_b.valid, 16'h0030 + 16'(i - 1));
            end
         end
         next_cyc();
      end
      for (int i = 0; i < 3; i++) begin
         if (i < 2) drive(1'b1, i == 0, 16'h0040 + 16'(i), i == 1);
         else       drive(1'b0, 1'b0, 16'h0, 1'b0);
         @(negedge clk);
         if (i > 0) begin
            n_tests++;
            if (out_b.valid !== 1'b1 || out_b.data !== 16'h0040 + 16'(i - 1) ||
                out_b.last !== (i == 2) || out_a.valid !== 1'b0) begin
               n_fail++;
               $display("FAIL si_b%0d: b=%b/%h/%b a_valid=%b want 1/%h/%b 0",
                        i - 1, out_b.valid, out_b.data, out_b.last, out_a.valid,
                        16'h0040 + 16'(i - 1), i == 2);
            end
         end
         next_cyc();
      end
   endtask

   // A stalled with a full slice blocks the input; B drains its beat independently
   task automatic test_backpressure();
      set_rdy(1'b0, 1'b0);
      drive(1'b1, 1'b1, 16'h00BB, 1'b1);
      next_cyc();
      drive(1'b1, 1'b0, 16'h00A1, 1'b0);
      @(negedge clk);
      n_tests++;
      if (in_s.ready !== 1'b1 || out_b.valid !== 1'b1 || out_b.data !== 16'h00BB) begin
         n_fail++;
         $display("FAIL bp_fill: ready=%b b=%b/%h want 1 1/00bb", in_s.ready, out_b.valid, out_b.data);
      end
      next_cyc();
      drive(1'b1, 1'b1, 16'h00A2, 1'b1);
      set_rdy(1'b0, 1'b1);
      for (int i = 0; i < 2; i++) begin
         @(negedge clk);
         n_tests++;
         if (in_s.ready !== 1'b0 || out_a.valid !== 1'b1 || out_a.data !== 16'h00A1) begin
            n_fail++;
            $display("FAIL bp_stall%0d: ready=%b a=%b/%h want 0 1/00a1", i, in_s.ready, out_a.valid, out_a.data);
         end
         n_tests++;
         if (out_b.valid !== (i == 0) || (i == 0 && out_b.data !== 16'h00BB)) begin
            n_fail++;
            $display("FAIL bp_bdrain%0d: b=%b/%h want %b/00bb", i, out_b.valid, out_b.data, i == 0);
         end
         next_cyc();
      end
      set_rdy(1'b1, 1'b1);
      @(negedge clk);
      n_tests++;
      if (in_s.ready !== 1'b1) begin
         n_fail++;
         $display("FAIL bp_release: ready=%b want 1", in_s.ready);
      end
      next_cyc();
      drive(1'b0, 1'b0, 16'h0, 1'b0);
      @(negedge clk);
      n_tests++;
      if (out_a.valid !== 1'b1 || out_a.data !== 16'h00A2 || out_a.last !== 1'b1 || out_b.valid !== 1'b0) begin
         n_fail++;
         $display("FAIL bp_a2: a=%b/%h/%b b_valid=%b want 1/00a2/1 0",
                  out_a.valid, out_a.data, out_a.last, out_b.valid);
      end
      next_cyc();
   endtask

   // Back-to-back single-beat frames go to different ports with no gap
   task automatic test_single_beat();
      set_rdy(1'b1, 1'b1);
      drive(1'b1, 1'b1, 16'h0010, 1'b1);
      next_cyc();
      drive(1'b1, 1'b0, 16'h0020, 1'b1);
      @(negedge clk);
      n_tests++;
      if (in_s.ready !== 1'b1 || out_b.valid !== 1'b1 || out_b.data !== 16'h0010 ||
          out_b.last !== 1'b1 || out_a.valid !== 1'b0) begin
         n_fail++;
         $display("FAIL sb_b: ready=%b b=%b/%h/%b a_valid=%b want 1 1/0010/1 0",
                  in_s.ready, out_b.valid, out_b.data, out_b.last, out_a.valid);
      end
      next_cyc();
      drive(1'b0, 1'b0, 16'h0, 1'b0);
      @(negedge clk);
      n_tests++;
      if (out_a.valid !== 1'b1 || out_a.data !== 16'h0020 || out_a.last !== 1'b1 || out_b.valid !== 1'b0) begin
         n_fail++;
         $display("FAIL sb_a: a=%b/%h/%b b_valid=%b want 1/0020/1 0",
                  out_a.valid, out_a.data, out_a.last, out_b.valid);
      end
      next_cyc();
   endtask

   // Reset in the middle of a frame to B: valids drop at once, next frame samples Sel afresh
   task automatic test_reset_midframe();
      set_rdy(1'b1, 1'b1);
      drive(1'b1, 1'b1, 16'h00B0, 1'b0);
      next_cyc();
      drive(1'b1, 1'b0, 16'h00B1, 1'b0);
      @(negedge clk);
      n_tests++;
      if (out_b.valid !== 1'b1 || out_b.data !== 16'h00B0) begin
         n_fail++;
         $display("FAIL rm_pre: b=%b/%h want 1/00b0", out_b.valid, out_b.data);
      end
      #1;
      rst_n = 1'b0;
      #1;
      n_tests++;
      if (out_b.valid !== 1'b0 || out_a.valid !== 1'b0 || dut.state !== IDLE) begin
         n_fail++;
         $display("FAIL rm_async: b=%b a=%b state=%0d want 0 0 %0d", out_b.valid, out_a.valid, dut.state, IDLE);
      end
      drive(1'b0, 1'b0, 16'h0, 1'b0);
      @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      next_cyc();
      drive(1'b1, 1'b0, 16'h00C0, 1'b1);
      next_cyc();
      drive(1'b0, 1'b0, 16'h0, 1'b0);
      @(negedge clk);
      n_tests++;
      if (out_a.valid !== 1'b1 || out_a.data !== 16'h00C0 || out_b.valid !== 1'b0) begin
         n_fail++;
         $display("FAIL rm_after: a=%b/%h b_valid=%b want 1/00c0 0", out_a.valid, out_a.data, out_b.valid);
      end
      next_cyc();
   endtask

   // Randomized traffic against a queue model: each port holds at most one pending beat
   task automatic test_random();
      logic [16:0] qa[$];
      logic [16:0] qb[$];
      bit          open_m;
      bit          dest_m;
      bit          r;
      bit          exp_rdy;
      bit          v;
      bit          l;
      logic [15:0] d;
      int          errs_before;
      errs_before = n_fail;
      apply_reset();
      open_m = 1'b0;
      dest_m = 1'b0;
      for (int c = 0; c < 3000; c++) begin
         v = ($urandom_range(0, 3) != 0);
         l = ($urandom_range(0, 3) == 0);
         d = 16'($urandom);
         drive(v, 1'($urandom), d, l);
         set_rdy($urandom_range(0, 3) != 0, $urandom_range(0, 2) != 0);
         @(negedge clk);
         r = open_m ? dest_m : sel;
         exp_rdy = r ? (qb.size() == 0 || out_b.ready) : (qa.size() == 0 || out_a.ready);
         n_tests++;
         if (in_s.ready !== exp_rdy) begin
            n_fail++;
            $display("FAIL rnd_ready@%0d: got %b want %b", c, in_s.ready, exp_rdy);
         end
         n_tests++;
         if (out_a.valid !== (qa.size() != 0) || (qa.size() != 0 && {out_a.last, out_a.data} !== qa[0])) begin
            n_fail++;
            $display("FAIL rnd_a@%0d: got %b/%h want %b/%h", c, out_a.valid,
                     {out_a.last, out_a.data}, qa.size() != 0, (qa.size() != 0) ? qa[0] : 17'h0);
         end
         n_tests++;
         if (out_b.valid !== (qb.size() != 0) || (qb.size() != 0 && {out_b.last, out_b.data} !== qb[0])) begin
            n_fail++;
            $display("FAIL rnd_b@%0d: got %b/%h want %b/%h", c, out_b.valid,
                     {out_b.last, out_b.data}, qb.size() != 0, (qb.size() != 0) ? qb[0] : 17'h0);
         end
         @(posedge clk);
         if (qa.size() != 0 && out_a.ready) void'(qa.pop_front());
         if (qb.size() != 0 && out_b.ready) void'(qb.pop_front());
         if (v && exp_rdy) begin
            if (r) qb.push_back({l, d});
            else   qa.push_back({l, d});
            open_m = !l;
            dest_m = r;
         end
         #1;
         if (n_fail - errs_before > 20) break;
      end
      drive(1'b0, 1'b0, 16'h0, 1'b0);
      set_rdy(1'b1, 1'b1);
      repeat (2) next_cyc();
   endtask

`ifdef DEMUX2_FRAME_CNT_EN
   // 257 single-beat frames to A wrap the A counter to 1; one frame to B gives 1
   task automatic test_frame_cnt();
      apply_reset();
      for (int i = 0; i < 257; i++) begin
         drive(1'b1, 1'b0, 16'(i), 1'b1);
         next_cyc();
      end
      drive(1'b0, 1'b0, 16'h0, 1'b0);
      @(negedge clk);
      n_tests++;
      if (frames_a !== 8'd1 || frames_b !== 8'd0) begin
         n_fail++;
         $display("FAIL cnt_wrap: a=%0d b=%0d want 1 0", frames_a, frames_b);
      end
      next_cyc();
      drive(1'b1, 1'b1, 16'h0055, 1'b1);
      next_cyc();
      drive(1'b0, 1'b0, 16'h0, 1'b0);
      @(negedge clk);
      n_tests++;
      if (frames_a !== 8'd1 || frames_b !== 8'd1) begin
         n_fail++;
         $display("FAIL cnt_b: a=%0d b=%0d want 1 1", frames_a, frames_b);
      end
      next_cyc();
   endtask
`endif

   initial begin
      drive(1'b0, 1'b0, 16'h0, 1'b0);
      set_rdy(1'b1, 1'b1);
      test_reset();
      test_frame_a();
      test_sel_ignored();
      test_backpressure();
      test_single_beat();
      test_reset_midframe();
      test_random();
`ifdef DEMUX2_FRAME_CNT_EN
      test_frame_cnt();
`endif
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/demux2_stream.md
# demux2_stream

Two-way stream demultiplexer for the 16-bit sample datapath. A single valid/ready input stream is steered, one frame at a time, to output A or B by a select bit sampled on each frame's first beat. Each output has its own one-entry register slice, so both outputs drain independently. It feeds the two branches of the processing pipeline that are later recombined by the 2:1 output mux.

## Interface
- DATA_W, 16, sample width in bits
- Clk  in  1  rising-edge clock
- Rst_n  in  1  asynchronous active-low reset
- Sel  in  1  route select (0 = A, 1 = B); used only on a frame's first beat
- In_Data  in  DATA_W  input sample
- In_Valid  in  1  input beat valid
- In_Last  in  1  last beat of frame
- In_Ready  out  1  input beat accepted when In_Valid & In_Ready
- Out_A_Data / Out_B_Data  out  DATA_W  registered output samples
- Out_A_Valid / Out_B_Valid  out  1  output beat valid
- Out_A_Last / Out_B_Last  out  1  registered copy of In_Last
- Out_A_Ready / Out_B_Ready  in  1  downstream ready

## Operation
- FSM states: IDLE (no frame open), FRAME_A, FRAME_B.
- Route: IDLE uses live Sel; FRAME_A → A; FRAME_B → B; Sel ignored mid-frame.
- Accept (In_Valid & In_Ready) in IDLE with In_Last=0 → FRAME_A/FRAME_B per Sel. With In_Last=1 (single-beat frame) → stays IDLE.
- Accept in FRAME_x with In_Last=1 → IDLE; otherwise stays.
- In_Ready = !Out_x_Valid | Out_x_Ready for the routed output x only. It never depends on the other output.
- Slice x on accept routed to x: loads Data/Last and sets Valid. Otherwise, Out_x_Valid & Out_x_Ready clears Valid. Load and drain in the same cycle keep Valid=1 with the new data.
- Unrouted slice keeps draining while the other output is being fed. A and B may both show Valid.
- Out_x_Data/Last hold their value while Valid & !Ready.
- In_Valid=0 never changes state. In_Ready may be high with In_Valid low.

## Timing
- Reset values: state IDLE, all Out_*_Valid=0, Out_*_Data=0, Out_*_Last=0. In_Ready is combinational from reset state, so it reads 1.
- Latency: beat accepted at edge n appears on Out_x at edge n (visible cycle n+1). One cycle, full throughput (1 beat/cycle) when downstream ready stays high.
- In_Ready is combinational from Out_x_Ready of the routed port. There is no combinational path from Sel to In_Ready outside IDLE.
- Reset asserted mid-frame: valids drop immediately (async), FSM → IDLE, and partial frames are discarded. First frame after reset release samples Sel afresh.
- Sel changing while a frame is open: no effect until the beat after In_Last is accepted.

## Configuration
- DEMUX2_FRAME_CNT_EN defined: adds outputs Frames_A, Frames_B (out, 8 bits). Each increments on acceptance of an In_Last beat routed to that port. Both wrap 255→0 and reset to 0.
- Undefined: ports and counters absent. Datapath behaviour is identical.

## Structure
- Package demux2_pkg: state encoding constants (IDLE=2'd0, FRAME_A=2'd1, FRAME_B=2'd2), DATA_W default, counter width 8.
- Sub-module stream_reg_slice (one-entry valid/ready register with Data+Last), instantiated twice. The FSM, route decode and In_Ready mux stay in the top.

## Test plan
- Reset → Out_A_Valid=Out_B_Valid=0, In_Ready=1, state IDLE; both Ready high, Sel=0, frame 0x0001..0x0004 (Last on 4th) → A shows 4 beats on consecutive cycles with 1-cycle latency; B silent.
- Sel=0 on first beat, Sel toggled to 1 on beats 2–3 of a 4-beat frame → all 4 beats on A. Next frame with Sel=1 → B.
- Out_A_Ready=0 with A slice full, frame routed to A → In_Ready=0 and Out_A_Data held. Meanwhile B drains its pending beat 0x00BB unaffected.
- Single-beat frames 0x0010 (Sel=1), 0x0020 (Sel=0) back-to-back → B gets 0x0010, A gets 0x0020 with Last=1, no idle cycle between.
- Rst_n pulsed low during beat 2 of a 5-beat frame to B → Out_B_Valid drops at once. After release, a new frame with Sel=0 goes to A.
- With DEMUX2_FRAME_CNT_EN: 257 single-beat frames to A → Frames_A=1, Frames_B=0.
